// File: rtl/freq_range_ctrl_if.sv
// Request/result bundle between a measurement consumer and freq_range_ctrl.
// start is a one-cycle request taken only while idle. resultValid rises once per
// measurement and holds count/highRange/overflow stable until resultAck or a new start.
interface freq_range_ctrl_if #(
  parameter int COUNT_W = 16
);
  logic               start;
  logic               resultAck;
  logic               busy;
  logic               resultValid;
  logic [COUNT_W-1:0] count;
  logic               highRange;
  logic               overflow;

  modport master (
    output start, resultAck,
    input  busy, resultValid, count, highRange, overflow
  );

  modport slave (
    input  start, resultAck,
    output busy, resultValid, count, highRange, overflow
  );
endinterface

// File: rtl/freq_range_ctrl.sv
// Auto-ranging gate-window edge counter: settles, counts, and switches the prescaler
// range at most once per measurement before publishing the result.
module freq_range_ctrl #(
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 8,
  parameter int COUNT_W       = 16,
  parameter int HIGH_THRESH   = 40000,
  parameter int LOW_THRESH    = 3000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    signalIn,
  output logic                    frequencyControl,
  output logic [1:0]              state_dbg,
  freq_range_ctrl_if.slave        bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, GATE, EVAL} state_t;

  localparam int TIMER_W = $clog2((GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GATE_LAST   = TIMER_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX     = '1;
  localparam logic [COUNT_W-1:0] HI_T        = COUNT_W'(HIGH_THRESH);
  localparam logic [COUNT_W-1:0] LO_T        = COUNT_W'(LOW_THRESH);

  state_t               state, state_next;
  logic [TIMER_W-1:0]   timer;
  logic [COUNT_W-1:0]   edge_cnt;
  logic                 edge_ovf;
  logic                 switched;
  logic                 sync1, sync2, dly;
  logic                 rise;
  logic                 switch_up, switch_dn;
  logic                 busy_q, valid_q, high_q, ovf_q;
  logic [COUNT_W-1:0]   count_q;

  assign rise      = sync2 & ~dly;
  assign switch_up = !switched && !frequencyControl && ((edge_cnt > HI_T) || edge_ovf);
  assign switch_dn = !switched &&  frequencyControl && (edge_cnt < LO_T);

  assign state_dbg       = state;
  assign bus.busy        = busy_q;
  assign bus.resultValid = valid_q;
  assign bus.count       = count_q;
  assign bus.highRange   = high_q;
  assign bus.overflow    = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SETTLE;
      SETTLE:  if (timer == SETTLE_LAST) state_next = GATE;
      GATE:    if (timer == GATE_LAST) state_next = EVAL;
      EVAL:    state_next = (switch_up || switch_dn) ? SETTLE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Timer restarts on every state change so SETTLE and GATE each run their exact length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  timer <= '0;
    else if (state == IDLE || state_next != state) timer <= '0;
    else                                         timer <= timer + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1            <= 1'b0;
      sync2            <= 1'b0;
      dly              <= 1'b0;
      edge_cnt         <= '0;
      edge_ovf         <= 1'b0;
      switched         <= 1'b0;
      frequencyControl <= 1'b0;
      busy_q           <= 1'b0;
      valid_q          <= 1'b0;
      count_q          <= '0;
      high_q           <= 1'b0;
      ovf_q            <= 1'b0;
    end else begin
      sync1 <= signalIn;
      sync2 <= sync1;
      dly   <= sync2;
      if (bus.resultAck) valid_q <= 1'b0;
      case (state)
        IDLE: begin
          // A start in the same cycle as resultAck still begins a new measurement.
          if (bus.start) begin
            busy_q   <= 1'b1;
            valid_q  <= 1'b0;
            switched <= 1'b0;
            edge_cnt <= '0;
            edge_ovf <= 1'b0;
          end
        end
        GATE: begin
          if (rise) begin
            if (edge_cnt == CNT_MAX) edge_ovf <= 1'b1;
            else                     edge_cnt <= edge_cnt + 1'b1;
          end
        end
        EVAL: begin
          if (switch_up || switch_dn) begin
            frequencyControl <= switch_up;
            switched         <= 1'b1;
            edge_cnt         <= '0;
            edge_ovf         <= 1'b0;
          end else begin
            count_q <= edge_cnt;
            high_q  <= frequencyControl;
            ovf_q   <= edge_ovf;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_freq_range_ctrl.sv
// Directed bench for freq_range_ctrl: two instances (8-bit and 4-bit counters) fed
// by a shared periodic source through a behavioural divide-by-8 prescaler.
module tb_freq_range_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  freq_range_ctrl_if #(.COUNT_W(8)) bus_a ();
  freq_range_ctrl_if #(.COUNT_W(4)) bus_b ();

  logic       fc_a, fc_b;
  logic [1:0] st_a, st_b;
  logic       sig_a, sig_b;

  // Source: raw toggles every half_per clocks; pres divides raw by 8.
  int         half_per  = 2;
  int         ph        = 0;
  logic       raw       = 1'b0;
  logic [2:0] pcnt      = 3'd0;
  logic       force_raw = 1'b0;
  logic       pres;

  always @(negedge clk) begin
    if (ph + 1 >= half_per) begin
      raw <= ~raw;
      ph  <= 0;
    end else begin
      ph <= ph + 1;
    end
  end

  always @(posedge raw) pcnt <= pcnt + 3'd1;

  assign pres  = pcnt[2];
  assign sig_a = fc_a ? pres : raw;
  assign sig_b = force_raw ? raw : (fc_b ? pres : raw);

  freq_range_ctrl #(
    .GATE_CYCLES(100), .SETTLE_CYCLES(4), .COUNT_W(8), .HIGH_THRESH(40), .LOW_THRESH(5)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .signalIn(sig_a),
    .frequencyControl(fc_a), .state_dbg(st_a), .bus(bus_a)
  );

  freq_range_ctrl #(
    .GATE_CYCLES(100), .SETTLE_CYCLES(4), .COUNT_W(4), .HIGH_THRESH(14), .LOW_THRESH(5)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .signalIn(sig_b),
    .frequencyControl(fc_b), .state_dbg(st_b), .bus(bus_b)
  );

  task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
    checks++;
    if (obs < exp - tol || obs > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Returns #1 after the clock edge that samples start.
  task automatic do_start(input int which);
    @(negedge clk);
    if (which == 0) bus_a.start = 1'b1;
    else            bus_b.start = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic wait_valid(input int which, input int budget, output int n);
    logic v;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      v = (which == 0) ? bus_a.resultValid : bus_b.resultValid;
    end while (!v && n < budget);
    if (!v) check("result_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int saved;
    rst_n = 1'b0;
    bus_a.start = 1'b0; bus_a.resultAck = 1'b0;
    bus_b.start = 1'b0; bus_b.resultAck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus_a.busy, 0);
    check("rst_valid", bus_a.resultValid, 0);
    check("rst_fc", fc_a, 0);
    check("rst_state", st_a, 0);
    @(negedge clk) rst_n = 1'b1;

    // 1: period 4, low range, no switch.
    half_per = 2;
    repeat (5) @(posedge clk);
    do_start(0);
    check("s1_busy", bus_a.busy, 1);
    wait_valid(0, 400, n);
    check("s1_latency", n, 105);
    check("s1_count", bus_a.count, 25, 1);
    check("s1_high", bus_a.highRange, 0);
    check("s1_ovf", bus_a.overflow, 0);
    check("s1_fc", fc_a, 0);
    check("s1_busy_done", bus_a.busy, 0);

    // 2: period 2 exceeds HIGH_THRESH in low range -> one switch up.
    half_per = 1;
    do_start(0);
    wait_valid(0, 600, n);
    check("s2_latency", n, 210);
    check("s2_count", bus_a.count, 6, 1);
    check("s2_high", bus_a.highRange, 1);
    check("s2_fc", fc_a, 1);

    // 3: period 40 is below LOW_THRESH in high range -> one switch down.
    half_per = 20;
    do_start(0);
    wait_valid(0, 600, n);
    check("s3_latency", n, 210);
    check("s3_count", bus_a.count, 2, 1);
    check("s3_high", bus_a.highRange, 0);
    check("s3_fc", fc_a, 0);

    // 4: 4-bit counter saturates in low range -> high range.
    half_per = 2;
    do_start(1);
    wait_valid(1, 600, n);
    check("s4_latency", n, 210);
    check("s4_count", bus_b.count, 3, 1);
    check("s4_high", bus_b.highRange, 1);
    check("s4_ovf", bus_b.overflow, 0);
    check("s4_fc", fc_b, 1);

    // 4b: raw signal forced past the prescaler saturates in high range.
    force_raw = 1'b1;
    half_per  = 1;
    do_start(1);
    wait_valid(1, 600, n);
    check("s4b_latency", n, 105);
    check("s4b_count", bus_b.count, 15);
    check("s4b_ovf", bus_b.overflow, 1);
    check("s4b_high", bus_b.highRange, 1);
    force_raw = 1'b0;

    // 5: start while busy is ignored; resultAck clears valid only.
    half_per = 2;
    do_start(0);
    @(negedge clk) bus_a.start = 1'b1;
    @(posedge clk);
    #1 bus_a.start = 1'b0;
    check("s5_busy", bus_a.busy, 1);
    wait_valid(0, 400, n);
    check("s5_latency", n + 1, 105);
    check("s5_count", bus_a.count, 25, 1);
    saved = bus_a.count;
    @(negedge clk) bus_a.resultAck = 1'b1;
    @(posedge clk);
    #1;
    check("s5_ack_valid", bus_a.resultValid, 0);
    check("s5_ack_count", bus_a.count, saved);
    repeat (2) @(posedge clk);
    @(negedge clk) bus_a.resultAck = 1'b0;
    check("s5_not_queued", bus_a.busy, 0);
    check("s5_valid_low", bus_a.resultValid, 0);

    // 6: reset mid-GATE clears everything immediately.
    do_start(0);
    repeat (50) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("s6_rst_busy", bus_a.busy, 0);
    check("s6_rst_valid", bus_a.resultValid, 0);
    check("s6_rst_count", bus_a.count, 0);
    check("s6_rst_state", st_a, 0);
    check("s6_rst_fc_b", fc_b, 0);
    check("s6_rst_high_b", bus_b.highRange, 0);
    check("s6_rst_ovf_b", bus_b.overflow, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    do_start(0);
    wait_valid(0, 400, n);
    check("s6_latency", n, 105);
    check("s6_count", bus_a.count, 25, 1);
    check("s6_high", bus_a.highRange, 0);

    // start and resultAck together: start wins.
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.resultAck = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    bus_a.resultAck = 1'b0;
    check("s6_both_valid", bus_a.resultValid, 0);
    check("s6_both_busy", bus_a.busy, 1);
    wait_valid(0, 400, n);
    check("s6_both_latency", n, 105);
    check("s6_both_count", bus_a.count, 25, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/freq_range_ctrl.md
Name: freq_range_ctrl

Overview:
- Auto-ranging measurement controller for the frequency counter.
- Drives frequencyControl into the FrequencyChoose prescaler and counts rising edges of its signalOut over a fixed gate window timed from the system clock.
- Switches the range at most once per measurement, re-measuring after each switch.
- Returns the edge count, the range used, and an overflow flag through a valid/ack handshake.

Parameters:
GATE_CYCLES, 1000, gate window length in clk cycles (>=2)
SETTLE_CYCLES, 8, cycles discarded after start or a range switch (>=3, flushes synchronizer and prescaler)
COUNT_W, 16, edge counter / result width
HIGH_THRESH, 40000, low-range count strictly above this (or overflow) -> switch to high range
LOW_THRESH, 3000, high-range count strictly below this -> switch to low range

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request; sampled only in IDLE
signalIn  input  1  measured signal (FrequencyChoose signalOut), asynchronous to clk
resultAck  input  1  consumer acknowledge; clears resultValid
frequencyControl  output  1  range select to FrequencyChoose; 1 = high (prescaled) range
busy  output  1  high from start acceptance until result published
resultValid  output  1  count/highRange/overflow valid
count  output  COUNT_W  edges counted in the final gate window
highRange  output  1  range used for the published count
overflow  output  1  counter saturated in the final gate window

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0: busy, resultValid, count, highRange, overflow, frequencyControl.
  - Synchronizer, counters and the switched flag cleared.
  - Reset asserted mid-measurement aborts it; nothing is published.
- Input path:
  - signalIn passes through a 2-FF synchronizer plus one delay FF.
  - A rising edge is counted when sync2=1 and delayed=0.
- Range state:
  - frequencyControl is a register equal to the current range.
  - It is sticky across measurements and changes only in EVAL.
- IDLE:
  - busy=0.
  - start=1 -> SETTLE: busy<=1, resultValid<=0, switched<=0, edge counter<=0, overflow<=0.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles; edges ignored; then -> GATE.
- GATE:
  - Lasts exactly GATE_CYCLES cycles; counts detected edges.
  - Counter saturates at 2^COUNT_W-1; any edge at saturation sets overflow.
  - Then -> EVAL.
- EVAL (1 cycle), checked in this order:
  - If switched=0, range=low, and (count>HIGH_THRESH or overflow): range<=high, switched<=1, clear counter/overflow, -> SETTLE.
  - If switched=0, range=high, and count<LOW_THRESH: range<=low, switched<=1, clear, -> SETTLE.
  - Otherwise: publish count, highRange (=current range), overflow; resultValid<=1, busy<=0, -> IDLE.
- Latency:
  - resultValid rises SETTLE_CYCLES+GATE_CYCLES+1 cycles after the edge that samples start.
  - Each range switch adds SETTLE_CYCLES+GATE_CYCLES+1.
- Handshake:
  - Published outputs hold stable while resultValid=1.
  - resultAck=1 clears resultValid on the next edge; outputs keep their values.
  - resultAck while resultValid=0 is ignored.
  - start while busy=1 is ignored (not queued).
  - start in IDLE while resultValid=1 is accepted and clears resultValid.
  - resultAck and start in the same cycle: start wins (new measurement, resultValid<=0).
- At most one range switch per measurement, so no oscillation. The result may be published with overflow=1 even in high range.
- Threshold comparisons are unsigned, COUNT_W bits wide.

Test Plan:
Bench common setup: GATE_CYCLES=100, SETTLE_CYCLES=4, COUNT_W=8, HIGH_THRESH=40, LOW_THRESH=5. The behavioural prescaler divides by 8 when frequencyControl=1.
1. signalIn period 4 clk, range low, start -> resultValid after 105 cycles; count=25±1, highRange=0, overflow=0, frequencyControl=0.
2. signalIn period 2 clk (toggle every cycle), range low, start -> one switch; resultValid after 210 cycles; count=6±1, highRange=1, frequencyControl=1.
3. After 2, signalIn period 40 clk, start -> prescaled count 0 <5 -> switch to low; count=2±1, highRange=0, frequencyControl=0; a single switch only.
4. COUNT_W=4, HIGH_THRESH=14, period 4 clk -> overflow, then high range; high-range count=3±1, overflow=0. Separately, a forced saturation in high range gives count=15, overflow=1.
5. start pulsed while busy=1 -> ignored, one result only. resultAck held 3 cycles -> resultValid low after the first edge; count unchanged.
6. rst_n low for 2 cycles mid-GATE -> all outputs 0 immediately. A new start afterwards gives a correct result from scenario-1 stimulus.
